// File: rtl/demux2_stream.sv
// 1-to-2 stream demux with a DEPTH-entry FIFO and a handshake counter per output.
// Latency 1 cycle in->out; in_ready drops only when the selected FIFO is full.

module demux2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Extra pointer MSB separates full from empty when the index bits match.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_i)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end
endmodule

module demux2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic             en_q;
  logic             full0, full1, empty0, empty1;
  logic             push0, push1, pop0, pop1;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // en_q holds in_ready low through reset and releases it on the first edge after.
  assign in_ready   = en_q & (in_sel ? ~full1 : ~full0);
  assign push0      = in_valid & in_ready & ~in_sel;
  assign push1      = in_valid & in_ready & in_sel;
  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;
  assign pop0       = out0_valid & out0_ready;
  assign pop1       = out1_valid & out1_ready;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

  demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push_i(push0), .din_i(in_data), .pop_i(pop0),
    .full_o(full0), .empty_o(empty0), .dout_o(out0_data)
  );

  demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push_i(push1), .din_i(in_data), .pop_i(pop1),
    .full_o(full1), .empty_o(empty1), .dout_o(out1_data)
  );

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (pop1) cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      en_q   <= 1'b1;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream: expected words are queued per output on acceptance and
// checked by a negedge monitor on every output handshake.
module tb_demux2_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sel = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out0_valid, out1_valid;
  logic       out0_ready = 1'b0;
  logic       out1_ready = 1'b0;
  logic [7:0] out0_data, out1_data;
  logic [3:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [3:0] exp_c0 = 4'd0;
  logic [3:0] exp_c1 = 4'd0;
  logic       chk_c0 = 1'b0;
  logic       chk_c1 = 1'b0;

  demux2_stream #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Producer must hold its offer until it is taken.
  assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_sel) && $stable(in_data)));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was accepted.
  task automatic send(input logic s, input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1; in_sel = s; in_data = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (s) q1.push_back(d); else q0.push_back(d);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    q0.delete(); q1.delete();
    exp_c0 = 4'd0; exp_c1 = 4'd0; chk_c0 = 1'b0; chk_c1 = 1'b0;
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_c0) chk("cnt0", 32'(cnt0), 32'(exp_c0));
      if (chk_c1) chk("cnt1", 32'(cnt1), 32'(exp_c1));
      chk_c0 = 1'b0;
      chk_c1 = 1'b0;
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      if (out0_valid && q0.size() != 0) begin
        chk("out0_data", 32'(out0_data), 32'(q0[0]));
        if (out0_ready) begin
          void'(q0.pop_front());
          exp_c0 = exp_c0 + 4'd1;
          chk_c0 = 1'b1;
        end
      end
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      if (out1_valid && q1.size() != 0) begin
        chk("out1_data", 32'(out1_data), 32'(q1[0]));
        if (out1_ready) begin
          void'(q1.pop_front());
          exp_c1 = exp_c1 + 4'd1;
          chk_c1 = 1'b1;
        end
      end
    end
  end

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_data", 32'(out1_data), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Mid-run reset with two words queued on out0
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    chk("t1_queued_valid", 32'(out0_valid), 32'd1);
    do_reset();
    chk("t1_out0_valid", 32'(out0_valid), 32'd0);
    chk("t1_out0_data", 32'(out0_data), 32'd0);
    chk("t1_cnt0", 32'(cnt0), 32'd0);
    chk("t1_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1_in_ready", 32'(in_ready), 32'd1);

    // Routing
    out0_ready = 1'b1; out1_ready = 1'b1;
    send(1'b0, 8'hA5);
    chk("t2_out0_latency", {out0_valid, out0_data}, {1'b1, 8'hA5});
    send(1'b1, 8'h3C);
    chk("t2_out1_latency", {out1_valid, out1_data}, {1'b1, 8'h3C});
    drain();
    chk("t2_cnt0", 32'(cnt0), 32'd1);
    chk("t2_cnt1", 32'(cnt1), 32'd1);

    // Full FIFO0 must not block FIFO1
    out0_ready = 1'b0;
    send(1'b0, 8'hB1);
    send(1'b0, 8'hB2);
    in_sel = 1'b0;
    @(negedge clk);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    send(1'b1, 8'hC4);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hB3; out0_ready = 1'b1;
    @(negedge clk);
    chk("t3_third_blocked", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_third_after_pop", 32'(in_ready), 32'd1);
    @(posedge clk);
    q0.push_back(8'hB3);
    #1 in_valid = 1'b0;
    drain();

    // Ordering under random backpressure
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i[0] ? 1'b0 : 1'b1, 8'(i));
      end
      begin
        repeat (60) begin
          @(posedge clk); #1;
          out0_ready = 1'($urandom_range(0, 1));
          out1_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out0_ready = 1'b1; out1_ready = 1'b1;
    drain();

    // Push and pop on FIFO0 in the same cycle
    out0_ready = 1'b0;
    send(1'b0, 8'h55);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h66; out0_ready = 1'b1;
    @(negedge clk);
    chk("t6_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    q0.push_back(8'h66);
    #1 in_valid = 1'b0; out0_ready = 1'b0;
    @(negedge clk);
    chk("t6_head", {out0_valid, out0_data}, {1'b1, 8'h66});
    chk("t6_occ1_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(1'b0, 8'h77);
    @(negedge clk);
    chk("t6_occ2_full", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out0_ready = 1'b1;
    drain();

    // Counter and pointer wrap on out1
    do_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out1_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(1'b1, 8'(8'h40 + i));
    drain();
    chk("t5_cnt1_wrap", 32'(cnt1), 32'd1);
    chk("t5_cnt0", 32'(cnt0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
